// File: rtl/eth_rx_framer.sv
// Ethernet receive framer. Takes the byte stream from the RMII receiver,
// strips the preamble and SFD, checks the FCS and the frame length, holds
// back the trailing four bytes so the FCS is never forwarded, and emits the
// frame as single-cycle beats with tlast/tuser plus one status pulse per frame.
module eth_rx_framer #(
  parameter int PRE_MIN = 5,
  parameter int MIN_LEN = 60,
  parameter int MAX_LEN = 1514
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_tdata,
  input  logic       rx_tvalid,
  input  logic       rx_active,
  output logic [7:0] m_tdata,
  output logic       m_tvalid,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic       frame_ok,
  output logic       crc_err,
  output logic       len_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PREAMBLE,
    S_DATA,
    S_DROP
  } state_t;

  localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
  localparam logic [2:0]  PRE_MIN_L   = 3'(PRE_MIN);
  // Length counter includes the four FCS bytes, so the limits are shifted by 4.
  localparam logic [15:0] LEN_LO      = 16'(MIN_LEN + 4);
  localparam logic [15:0] LEN_HI      = 16'(MAX_LEN + 4);

  state_t      state_q, state_d;
  logic [2:0]  pcnt_q, pcnt_d;
  logic [31:0] crc_q, crc_d;
  logic [15:0] len_q, len_d;
  logic [7:0]  buf_q [5];
  logic [7:0]  buf_d [5];
  logic [2:0]  bcnt_q, bcnt_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic        m_tuser_q, m_tuser_d;
  logic        frame_ok_q, frame_ok_d;
  logic        crc_err_q, crc_err_d;
  logic        len_err_q, len_err_d;

  // Reflected CRC-32 update for one byte, LSB first.
  function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  // Next-state, buffer, CRC and output computation for the framer FSM.
  always_comb begin
    state_d    = state_q;
    pcnt_d     = pcnt_q;
    crc_d      = crc_q;
    len_d      = len_q;
    bcnt_d     = bcnt_q;
    for (int i = 0; i < 5; i++) begin
      buf_d[i] = buf_q[i];
    end
    m_tdata_d  = 8'h00;
    m_tvalid_d = 1'b0;
    m_tlast_d  = 1'b0;
    m_tuser_d  = 1'b0;
    frame_ok_d = 1'b0;
    crc_err_d  = 1'b0;
    len_err_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rx_tvalid && rx_active) begin
          if (rx_tdata == 8'h55) begin
            state_d = S_PREAMBLE;
            pcnt_d  = 3'd1;
          end else begin
            state_d = S_DROP;
          end
        end
      end

      S_PREAMBLE: begin
        if (!rx_active) begin
          state_d = S_IDLE;
        end else if (rx_tvalid) begin
          if (rx_tdata == 8'h55) begin
            pcnt_d = (pcnt_q == 3'd7) ? 3'd7 : pcnt_q + 3'd1;
          end else if (rx_tdata == 8'hD5 && pcnt_q >= PRE_MIN_L) begin
            state_d = S_DATA;
            crc_d   = CRC_INIT;
            len_d   = 16'd0;
            bcnt_d  = 3'd0;
          end else begin
            state_d   = S_DROP;
            len_err_d = 1'b1;
          end
        end
      end

      S_DATA: begin
        if (!rx_active) begin
          state_d = S_IDLE;
          if (bcnt_q == 3'd5) begin
            m_tvalid_d = 1'b1;
            m_tlast_d  = 1'b1;
            m_tdata_d  = buf_q[0];
            if (len_q < LEN_LO || len_q > LEN_HI) begin
              m_tuser_d = 1'b1;
              len_err_d = 1'b1;
            end else if (crc_q != CRC_RESIDUE) begin
              m_tuser_d = 1'b1;
              crc_err_d = 1'b1;
            end else begin
              frame_ok_d = 1'b1;
            end
          end else begin
            len_err_d = 1'b1;
          end
        end else if (rx_tvalid) begin
          crc_d = crc_next(crc_q, rx_tdata);
          len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
          if (bcnt_q == 3'd5) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = buf_q[0];
            for (int i = 0; i < 4; i++) begin
              buf_d[i] = buf_q[i+1];
            end
            buf_d[4] = rx_tdata;
          end else begin
            buf_d[bcnt_q] = rx_tdata;
            bcnt_d        = bcnt_q + 3'd1;
          end
        end
      end

      S_DROP: begin
        if (!rx_active) begin
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pcnt_q     <= 3'd0;
      crc_q      <= CRC_INIT;
      len_q      <= 16'd0;
      bcnt_q     <= 3'd0;
      for (int i = 0; i < 5; i++) begin
        buf_q[i] <= 8'h00;
      end
      m_tdata_q  <= 8'h00;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tuser_q  <= 1'b0;
      frame_ok_q <= 1'b0;
      crc_err_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      crc_q      <= crc_d;
      len_q      <= len_d;
      bcnt_q     <= bcnt_d;
      for (int i = 0; i < 5; i++) begin
        buf_q[i] <= buf_d[i];
      end
      m_tdata_q  <= m_tdata_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tuser_q  <= m_tuser_d;
      frame_ok_q <= frame_ok_d;
      crc_err_q  <= crc_err_d;
      len_err_q  <= len_err_d;
    end
  end

  assign m_tdata  = m_tdata_q;
  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tuser  = m_tuser_q;
  assign frame_ok = frame_ok_q;
  assign crc_err  = crc_err_q;
  assign len_err  = len_err_q;

endmodule
